// File: rtl/aclk_load_ctrl.sv
// aclk_load_ctrl: arbitrates two requesters that load the alarm-clock core's
// clock or alarm setting. Requests are range-checked, applied with a single
// load strobe, and clock loads are confirmed by reading the time back.
module aclk_load_ctrl #(
    parameter int unsigned VERIFY_TIMEOUT = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [1:0]  req_alarm,
    input  logic [13:0] req_hm0,
    input  logic [13:0] req_hm1,
    output logic [1:0]  H_in1,
    output logic [3:0]  H_in0,
    output logic [3:0]  M_in1,
    output logic [3:0]  M_in0,
    output logic        LD_time,
    output logic        LD_alarm,
    input  logic [1:0]  H_out1,
    input  logic [3:0]  H_out0,
    input  logic [3:0]  M_out1,
    input  logic [3:0]  M_out0,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [1:0]  err_code,
    output logic        grant_id
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_HOLD   = 2'd2,
        ST_VERIFY = 2'd3
    } state_t;

    localparam logic [3:0] VCNT_LAST = 4'(VERIFY_TIMEOUT - 32'd1);

    // HH:MM payload is a legal 24-hour BCD time.
    function automatic logic hm_valid(input logic [13:0] hm);
        return (hm[13:12] <= 2'd2) && (hm[11:8] <= 4'd9) &&
               !((hm[13:12] == 2'd2) && (hm[11:8] > 4'd3)) &&
               (hm[7:4] <= 4'd5) && (hm[3:0] <= 4'd9);
    endfunction

    // BCD time plus one minute, wrapping 23:59 to 00:00.
    function automatic logic [13:0] hm_inc(input logic [13:0] hm);
        logic [1:0] h1;
        logic [3:0] h0;
        logic [3:0] m1;
        logic [3:0] m0;
        h1 = hm[13:12];
        h0 = hm[11:8];
        m1 = hm[7:4];
        m0 = hm[3:0];
        if (m0 != 4'd9) begin
            m0 = m0 + 4'd1;
        end else begin
            m0 = 4'd0;
            if (m1 != 4'd5) begin
                m1 = m1 + 4'd1;
            end else begin
                m1 = 4'd0;
                if ((h1 == 2'd2) && (h0 == 4'd3)) begin
                    h1 = 2'd0;
                    h0 = 4'd0;
                end else if (h0 == 4'd9) begin
                    h1 = h1 + 2'd1;
                    h0 = 4'd0;
                end else begin
                    h0 = h0 + 4'd1;
                end
            end
        end
        return {h1, h0, m1, m0};
    endfunction

    state_t      state_q, state_d;
    logic        last_grant_q, last_grant_d;
    logic [13:0] cap_hm_q, cap_hm_d;
    logic        cap_alarm_q, cap_alarm_d;
    logic        cap_id_q, cap_id_d;
    logic [13:0] din_q, din_d;
    logic        ld_time_q, ld_time_d;
    logic        ld_alarm_q, ld_alarm_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [1:0]  err_code_q, err_code_d;
    logic        grant_id_q, grant_id_d;
    logic [3:0]  vcnt_q, vcnt_d;

    logic        grant_s;
    logic [1:0]  req_ready_s;
    logic [13:0] payload_s;
    logic        alarm_s;
    logic [13:0] readback_s;
    logic        match_s;

    // Round-robin grant and combinational ready, offered only in IDLE.
    always_comb begin
        if (req_valid == 2'b11) begin
            grant_s = ~last_grant_q;
        end else if (req_valid[1]) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end
        if (reset_n && (state_q == ST_IDLE) && (req_valid != 2'b00)) begin
            req_ready_s = grant_s ? 2'b10 : 2'b01;
        end else begin
            req_ready_s = 2'b00;
        end
        payload_s  = grant_s ? req_hm1 : req_hm0;
        alarm_s    = grant_s ? req_alarm[1] : req_alarm[0];
        readback_s = {H_out1, H_out0, M_out1, M_out0};
        match_s    = (readback_s == cap_hm_q) || (readback_s == hm_inc(cap_hm_q));
    end

    // Next-state and registered-output logic of the load sequence.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cap_hm_d     = cap_hm_q;
        cap_alarm_d  = cap_alarm_q;
        cap_id_d     = cap_id_q;
        din_d        = din_q;
        ld_time_d    = 1'b0;
        ld_alarm_d   = 1'b0;
        done_d       = 1'b0;
        err_d        = 1'b0;
        err_code_d   = 2'd0;
        grant_id_d   = 1'b0;
        vcnt_d       = vcnt_q;
        case (state_q)
            ST_IDLE: begin
                if (req_ready_s != 2'b00) begin
                    last_grant_d = grant_s;
                    cap_id_d     = grant_s;
                    if (hm_valid(payload_s)) begin
                        cap_hm_d    = payload_s;
                        cap_alarm_d = alarm_s;
                        din_d       = payload_s;
                        ld_time_d   = ~alarm_s;
                        ld_alarm_d  = alarm_s;
                        state_d     = ST_LOAD;
                    end else begin
                        err_d      = 1'b1;
                        err_code_d = 2'd1;
                        grant_id_d = grant_s;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (cap_alarm_q) begin
                    done_d     = 1'b1;
                    grant_id_d = cap_id_q;
                    state_d    = ST_IDLE;
                end else begin
                    vcnt_d  = 4'd0;
                    state_d = ST_VERIFY;
                end
            end
            ST_VERIFY: begin
                if (match_s) begin
                    done_d     = 1'b1;
                    grant_id_d = cap_id_q;
                    state_d    = ST_IDLE;
                end else if (vcnt_q == VCNT_LAST) begin
                    err_d      = 1'b1;
                    err_code_d = 2'd2;
                    grant_id_d = cap_id_q;
                    state_d    = ST_IDLE;
                end else begin
                    vcnt_d = vcnt_q + 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            cap_hm_q     <= 14'd0;
            cap_alarm_q  <= 1'b0;
            cap_id_q     <= 1'b0;
            din_q        <= 14'd0;
            ld_time_q    <= 1'b0;
            ld_alarm_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            err_code_q   <= 2'd0;
            grant_id_q   <= 1'b0;
            vcnt_q       <= 4'd0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cap_hm_q     <= cap_hm_d;
            cap_alarm_q  <= cap_alarm_d;
            cap_id_q     <= cap_id_d;
            din_q        <= din_d;
            ld_time_q    <= ld_time_d;
            ld_alarm_q   <= ld_alarm_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
            err_code_q   <= err_code_d;
            grant_id_q   <= grant_id_d;
            vcnt_q       <= vcnt_d;
        end
    end

    assign req_ready = req_ready_s;
    assign H_in1     = din_q[13:12];
    assign H_in0     = din_q[11:8];
    assign M_in1     = din_q[7:4];
    assign M_in0     = din_q[3:0];
    assign LD_time   = ld_time_q;
    assign LD_alarm  = ld_alarm_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign err_code  = err_code_q;
    assign grant_id  = grant_id_q;

endmodule

// File: tb/tb_aclk_load_ctrl.sv
// Directed bench for aclk_load_ctrl: expected done/err events are queued
// when a transfer is accepted and matched against the DUT as they appear.
module tb_aclk_load_ctrl;

    typedef struct {
        logic       is_err;
        logic [1:0] code;
        logic       id;
        int         cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [1:0]  req_alarm;
    logic [13:0] req_hm0;
    logic [13:0] req_hm1;
    logic [1:0]  H_in1;
    logic [3:0]  H_in0;
    logic [3:0]  M_in1;
    logic [3:0]  M_in0;
    logic        LD_time;
    logic        LD_alarm;
    logic [13:0] rb;
    logic        busy;
    logic        done;
    logic        err;
    logic [1:0]  err_code;
    logic        grant_id;

    exp_t sbq[$];
    int   cyc = 0;
    int   nvec = 0;
    int   nmis = 0;

    aclk_load_ctrl #(.VERIFY_TIMEOUT(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_alarm(req_alarm),
        .req_hm0(req_hm0), .req_hm1(req_hm1),
        .H_in1(H_in1), .H_in0(H_in0), .M_in1(M_in1), .M_in0(M_in0),
        .LD_time(LD_time), .LD_alarm(LD_alarm),
        .H_out1(rb[13:12]), .H_out0(rb[11:8]), .M_out1(rb[7:4]), .M_out0(rb[3:0]),
        .busy(busy), .done(done), .err(err), .err_code(err_code), .grant_id(grant_id)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nmis++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge and check events and invariants.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        cyc++;
        chk("done_err_excl", 32'(done & err), 32'd0);
        chk("ready_not_both", 32'(req_ready == 2'b11), 32'd0);
        chk("ld_not_both", 32'(LD_time & LD_alarm), 32'd0);
        if (!done && !err) begin
            chk("tags_idle_zero", 32'({grant_id, err_code}), 32'd0);
        end else if (sbq.size() == 0) begin
            chk("unexpected_event", 32'({done, err}), 32'd0);
        end else begin
            e = sbq.pop_front();
            chk("evt_err", 32'(err), 32'(e.is_err));
            chk("evt_code", 32'(err_code), 32'(e.code));
            chk("evt_id", 32'(grant_id), 32'(e.id));
            chk("evt_cycle", 32'(cyc), 32'(e.cyc));
        end
    endtask

    task automatic push_exp(input logic is_err, input logic [1:0] code, input logic id, input int at);
        exp_t e;
        e.is_err = is_err;
        e.code   = code;
        e.id     = id;
        e.cyc    = at;
        sbq.push_back(e);
    endtask

    // Offer one request, wait for its grant, queue the expected outcome.
    task automatic xfer(input logic id, input logic alarm, input logic [13:0] hm,
                        input logic push, input logic is_err, input logic [1:0] code,
                        input int lat, output int t);
        int n;
        req_alarm[id] = alarm;
        if (id) req_hm1 = hm;
        else    req_hm0 = hm;
        req_valid[id] = 1'b1;
        #1;
        n = 0;
        while (!req_ready[id] && n < 20) begin
            tick();
            #1;
            n++;
        end
        chk("grant_wait", 32'(req_ready[id]), 32'd1);
        t = cyc;
        if (push) push_exp(is_err, code, id, cyc + lat);
        tick();
        req_valid[id] = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 30) begin
            tick();
            n++;
        end
        chk("drain", 32'(sbq.size()), 32'd0);
        tick();
    endtask

    function automatic logic [21:0] all_out();
        return {H_in1, H_in0, M_in1, M_in0, LD_time, LD_alarm, busy, done, err, err_code, grant_id};
    endfunction

    initial begin
        int t;
        int t2;
        int prev;
        int n;
        reset_n   = 1'b0;
        req_valid = 2'b00;
        req_alarm = 2'b00;
        req_hm0   = 14'd0;
        req_hm1   = 14'd0;
        rb        = 14'd0;
        tick();
        tick();
        chk("reset_outputs", 32'(all_out()), 32'd0);
        reset_n = 1'b1;
        tick();

        // Clock load 12:34 from requester 0, readback matches immediately.
        rb = 14'h1234;
        xfer(1'b0, 1'b0, 14'h1234, 1'b1, 1'b0, 2'd0, 4, t);
        chk("clk_ld_time_t1", 32'(LD_time), 32'd1);
        chk("clk_ld_alarm_t1", 32'(LD_alarm), 32'd0);
        chk("clk_digits", 32'({H_in1, H_in0, M_in1, M_in0}), 32'h1234);
        chk("clk_busy_t1", 32'(busy), 32'd1);
        tick();
        chk("clk_ld_time_t2", 32'(LD_time), 32'd0);
        chk("clk_ld_alarm_t2", 32'(LD_alarm), 32'd0);
        drain();

        // Round robin after reset with both requesters loading alarms.
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        req_alarm = 2'b11;
        req_hm0   = 14'h0630;
        req_hm1   = 14'h0715;
        req_valid = 2'b11;
        #1;
        prev = 0;
        for (int i = 0; i < 4; i++) begin
            n = 0;
            while (req_ready == 2'b00 && n < 20) begin
                tick();
                #1;
                n++;
            end
            chk("rr_ready", 32'(req_ready), (i % 2 == 1) ? 32'd2 : 32'd1);
            if (i > 0) chk("rr_grant_at_done", 32'(cyc), 32'(prev + 3));
            prev = cyc;
            push_exp(1'b0, 2'd0, 1'(i % 2), cyc + 3);
            tick();
            #1;
        end
        req_valid = 2'b00;
        drain();

        // Bad BCD from requester 1: 24:00 then 13:60 back to back.
        xfer(1'b1, 1'b0, 14'h2400, 1'b1, 1'b1, 2'd1, 1, t);
        chk("bad1_no_ld", 32'({LD_time, LD_alarm}), 32'd0);
        chk("bad1_busy", 32'(busy), 32'd0);
        xfer(1'b1, 1'b0, 14'h1360, 1'b1, 1'b1, 2'd1, 1, t2);
        chk("bad2_next_cycle", 32'(t2), 32'(t + 1));
        chk("bad2_no_ld", 32'({LD_time, LD_alarm}), 32'd0);
        chk("bad2_busy", 32'(busy), 32'd0);
        chk("bad_digits_kept", 32'({H_in1, H_in0, M_in1, M_in0}), 32'h0715);
        drain();

        // Alarm load 06:30: no verify phase.
        xfer(1'b0, 1'b1, 14'h0630, 1'b1, 1'b0, 2'd0, 3, t);
        chk("alm_ld_alarm_t1", 32'(LD_alarm), 32'd1);
        chk("alm_ld_time_t1", 32'(LD_time), 32'd0);
        tick();
        chk("alm_ld_alarm_t2", 32'(LD_alarm), 32'd0);
        chk("alm_busy_t2", 32'(busy), 32'd1);
        tick();
        chk("alm_busy_t3", 32'(busy), 32'd0);
        tick();
        chk("alm_digits_held", 32'({H_in1, H_in0, M_in1, M_in0}), 32'h0630);
        chk("alm_busy_t4", 32'(busy), 32'd0);
        drain();

        // 23:59 accepted when readback has already wrapped to 00:00.
        rb = 14'h0000;
        xfer(1'b0, 1'b0, 14'h2359, 1'b1, 1'b0, 2'd0, 4, t);
        drain();

        // Readback stuck at 09:59 after loading 10:00: verify timeout.
        rb = 14'h0959;
        xfer(1'b0, 1'b0, 14'h1000, 1'b1, 1'b1, 2'd2, 7, t);
        drain();

        // Readback turns into L+1 (08:16) during the second verify cycle.
        rb = 14'h0000;
        xfer(1'b1, 1'b0, 14'h0815, 1'b1, 1'b0, 2'd0, 5, t);
        tick();
        tick();
        tick();
        rb = 14'h0816;
        drain();

        // Reset in VERIFY aborts silently; requester 0 wins afterwards.
        rb = 14'h0000;
        xfer(1'b0, 1'b0, 14'h1111, 1'b0, 1'b0, 2'd0, 0, t);
        tick();
        tick();
        tick();
        reset_n = 1'b0;
        tick();
        chk("midrst_outputs", 32'(all_out()), 32'd0);
        chk("midrst_ready", 32'(req_ready), 32'd0);
        tick();
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        req_alarm = 2'b11;
        req_hm0   = 14'h0100;
        req_hm1   = 14'h0200;
        req_valid = 2'b11;
        #1;
        chk("postrst_first_grant", 32'(req_ready), 32'd1);
        push_exp(1'b0, 2'd0, 1'b0, cyc + 3);
        tick();
        req_valid = 2'b00;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

// File: doc/aclk_load_ctrl.md
# aclk_load_ctrl

Load controller for the alarm-clock core's setting port. It arbitrates between two requesters (0 = front panel, 1 = time-sync source), each asking to load either the clock or the alarm. It range-checks the requested HH:MM, drives `H_in1`/`H_in0`/`M_in1`/`M_in0` with a single-cycle `LD_time` or `LD_alarm`, and for clock loads confirms the result by reading back `H_out*`/`M_out*`. It sits between the requesters and the alarm-clock core and runs on the core's clock.

## Interface

Parameters:
- `VERIFY_TIMEOUT`, default 4: cycles spent in VERIFY before a clock load is declared failed (range 1–15).

Ports:
- `clk` in 1: core clock, rising edge.
- `reset_n` in 1: synchronous, active-low reset.
- `req_valid` in 2: per-requester request valid.
- `req_ready` out 2: per-requester ready. A transfer occurs when `valid & ready`.
- `req_alarm` in 2: per-requester target; 1 = alarm, 0 = clock.
- `req_hm0`, `req_hm1` in 14 each: payload `{H1[1:0], H0[3:0], M1[3:0], M0[3:0]}` in BCD.
- `H_in1` out 2, `H_in0` out 4, `M_in1` out 4, `M_in0` out 4: setting digits to the core.
- `LD_time` out 1, `LD_alarm` out 1: load strobes to the core.
- `H_out1` in 2, `H_out0` in 4, `M_out1` in 4, `M_out0` in 4: clock readback from the core.
- `busy` out 1: high whenever the FSM is not in IDLE.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: one-cycle failure pulse.
- `err_code` out 2: 0 = none, 1 = bad BCD, 2 = verify timeout; valid with `err`.
- `grant_id` out 1: requester reported by `done`/`err`.

## Operation

- **FSM states:** IDLE, LOAD, HOLD, VERIFY.
- **IDLE, arbitration:**
  - Round-robin between active `req_valid` bits; the requester not granted last wins ties.
  - The `last_grant` register resets to 1, so requester 0 wins first.
  - `req_ready[g]` is combinational and asserted only in IDLE, only for the granted `g`. The other ready bit stays 0.
- **On transfer:** capture payload, target and id.
- **Validity check:** H1 ≤ 2; H0 ≤ 9; if H1 == 2 then H0 ≤ 3; M1 ≤ 5; M0 ≤ 9.
  - Invalid: stay in IDLE, pulse `err` with code 1 next cycle, strobes untouched.
  - Valid: go to LOAD.
- **LOAD:**
  - Present captured digits on `H_in*`/`M_in*`.
  - Assert exactly one strobe (`LD_time` or `LD_alarm`) for exactly one cycle.
  - Go to HOLD.
- **HOLD:**
  - Strobes low; digits held stable.
  - Alarm target: pulse `done` and go to IDLE.
  - Clock target: go to VERIFY with the verify counter cleared.
- **VERIFY:**
  - Each cycle, compare readback HH:MM against the loaded value L and against L+1 minute.
  - L+1 uses BCD increment: M0 9→0 carries to M1; M1 5→0 carries to the hour; 23:59 → 00:00.
  - Either match: pulse `done`, go to IDLE.
  - No match after `VERIFY_TIMEOUT` cycles: pulse `err` with code 2, go to IDLE.
- **Outputs outside LOAD/HOLD:** `H_in*`/`M_in*` hold the last loaded value. `LD_*` are always 0 outside LOAD.
- **Reset:** every output goes to 0, the FSM goes to IDLE, and `last_grant` goes to 1. Reset asserted mid-transaction aborts it silently: no `done`/`err`.

## Timing

- All outputs are registered except `req_ready`.
- Transfer accepted at cycle T (IDLE):
  - Invalid payload: `err` at T+1. New transfer possible at T+1.
  - Valid payload: `LD_*` high at T+1 only, HOLD at T+2.
  - Alarm load: `done` at T+3.
  - Clock load: VERIFY occupies T+3 … T+2+`VERIFY_TIMEOUT`. A match seen in cycle T+3+k gives `done` at T+4+k. Timeout gives `err` at T+3+`VERIFY_TIMEOUT`.
- A new grant may occur in the same cycle `done`/`err` is high, because the FSM is already in IDLE.
- `done` and `err` are never high together. `grant_id` and `err_code` are valid only while either is high, and read 0 otherwise.
- A requester dropping `req_valid` without a transfer is legal and has no effect.

## Test plan

- **Clock load, match:** req0 loads clock 12:34; readback = 12:34 from T+3. Require `LD_time` = 1 at T+1 only, `H_in1`=1, `H_in0`=2, `M_in1`=3, `M_in0`=4, `done` at T+4, `grant_id`=0, `LD_alarm` never high.
- **Round-robin:** after reset, both requesters hold `req_valid` with valid alarm loads. Require grant order 0, 1, 0, 1, with each grant in the same cycle as the prior `done`, and `req_ready` never 2'b11.
- **Bad BCD:** req1 loads clock 24:00, then 13:60. Require `err` with `err_code`=1 and `grant_id`=1 at T+1 for each, no `LD_*` pulse, `busy` never high.
- **Alarm load:** req0 loads alarm 06:30. Require `LD_alarm` at T+1, `done` at T+3, no VERIFY, digits held at 0,6,3,0 afterwards.
- **Verify boundaries:**
  - Load clock 23:59 with readback 00:00: require `done` (wrap accepted).
  - Load 10:00 with readback stuck at 09:59 and `VERIFY_TIMEOUT`=4: require `err` with `err_code`=2 at T+7.
- **Mid-operation reset:** `reset_n` low during VERIFY. Next cycle require all outputs 0 and no `done`/`err`. First grant after release goes to requester 0.
